// File: rtl/mem_req_arbiter_2x1_pkg.sv
// Memory message types shared by the caches, arbiter and test memory.
// Also holds the port-ID width used to tag in-flight requests.
package mem_req_arbiter_2x1_pkg;

  localparam int c_port_id_nbits = 1;

  typedef enum logic [2:0] {
    MEM_TYPE_READ  = 3'd0,
    MEM_TYPE_WRITE = 3'd1,
    MEM_TYPE_INIT  = 3'd2
  } mem_type_e;

  typedef struct packed {
    mem_type_e    type_;
    logic [7:0]   opaque;
    logic [31:0]  addr;
    logic [3:0]   len;
    logic [127:0] data;
  } mem_req_16B_t;

  typedef struct packed {
    mem_type_e    type_;
    logic [7:0]   opaque;
    logic [1:0]   test;
    logic [3:0]   len;
    logic [127:0] data;
  } mem_resp_16B_t;

  typedef logic [c_port_id_nbits-1:0] port_id_t;

endpackage

// File: rtl/mem_arb_id_fifo.sv
// In-order FIFO of port IDs for requests in flight to memory.
// Push is dropped when full and pop when empty, so callers may not overrun it.
module mem_arb_id_fifo #(
  parameter int p_width = 1,
  parameter int p_depth = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic [p_width-1:0] wdata,
  input  logic               pop,
  output logic [p_width-1:0] rdata,
  output logic               full,
  output logic               empty
);

  localparam int c_ptr_nbits = $clog2(p_depth);
  localparam int c_cnt_nbits = c_ptr_nbits + 1;

  logic [p_width-1:0]     mem_q [p_depth];
  logic [p_width-1:0]     mem_d [p_depth];
  logic [c_ptr_nbits-1:0] head_q, head_d;
  logic [c_ptr_nbits-1:0] tail_q, tail_d;
  logic [c_cnt_nbits-1:0] count_q, count_d;
  logic                   do_push;
  logic                   do_pop;

  assign full    = (count_q == c_cnt_nbits'(p_depth));
  assign empty   = (count_q == '0);
  assign rdata   = mem_q[head_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (do_push) begin
      mem_d[tail_q] = wdata;
      tail_d        = tail_q + c_ptr_nbits'(1);
    end
    if (do_pop) begin
      head_d = head_q + c_ptr_nbits'(1);
    end
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + c_cnt_nbits'(1);
      2'b01:   count_d = count_q - c_cnt_nbits'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < p_depth; i++) begin
        mem_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mem_req_arbiter_2x1.sv
// Round-robin 2:1 arbiter onto one 16B memory port; responses are
// steered back in order using the port ID recorded at request time.
module mem_req_arbiter_2x1
  import mem_req_arbiter_2x1_pkg::*;
#(
  parameter int p_num_outstanding = 4
) (
  input  logic          clk,
  input  logic          reset,

  input  mem_req_16B_t  req0_msg,
  input  logic          req0_val,
  output logic          req0_rdy,

  input  mem_req_16B_t  req1_msg,
  input  logic          req1_val,
  output logic          req1_rdy,

  output mem_resp_16B_t resp0_msg,
  output logic          resp0_val,
  input  logic          resp0_rdy,

  output mem_resp_16B_t resp1_msg,
  output logic          resp1_val,
  input  logic          resp1_rdy,

  output mem_req_16B_t  memreq_msg,
  output logic          memreq_val,
  input  logic          memreq_rdy,

  input  mem_resp_16B_t memresp_msg,
  input  logic          memresp_val,
  output logic          memresp_rdy
);

  logic     prio_q, prio_d;
  logic     gnt0;
  logic     gnt1;
  logic     memreq_fire;
  logic     memresp_fire;
  logic     id_full;
  logic     id_empty;
  port_id_t id_head;
  port_id_t id_push;

  // Grant looks only at vals and prio, so no rdy feeds back into a val.
  always_comb begin
    gnt0 = req0_val && (!req1_val || (prio_q == 1'b0));
    gnt1 = req1_val && (!req0_val || (prio_q == 1'b1));
  end

  assign memreq_val  = (req0_val || req1_val) && !id_full;
  assign memreq_msg  = gnt1 ? req1_msg : req0_msg;
  assign req0_rdy    = gnt0 && memreq_rdy && !id_full;
  assign req1_rdy    = gnt1 && memreq_rdy && !id_full;
  assign memreq_fire = memreq_val && memreq_rdy;
  assign id_push     = port_id_t'(gnt1);

  always_comb begin
    prio_d = prio_q;
    if (memreq_fire) begin
      prio_d = !gnt1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end

  assign resp0_msg    = memresp_msg;
  assign resp1_msg    = memresp_msg;
  assign resp0_val    = memresp_val && !id_empty && (id_head == 1'b0);
  assign resp1_val    = memresp_val && !id_empty && (id_head == 1'b1);
  assign memresp_rdy  = !id_empty && (id_head ? resp1_rdy : resp0_rdy);
  assign memresp_fire = memresp_val && memresp_rdy;

  mem_arb_id_fifo #(
    .p_width (c_port_id_nbits),
    .p_depth (p_num_outstanding)
  ) u_id_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (memreq_fire),
    .wdata (id_push),
    .pop   (memresp_fire),
    .rdata (id_head),
    .full  (id_full),
    .empty (id_empty)
  );

  // A response with nothing outstanding means memory broke protocol.
  a_no_resp_when_empty: assert property (
    @(posedge clk) disable iff (reset) !(memresp_val && id_empty)
  );

endmodule

// File: tb/tb_mem_req_arbiter_2x1.sv
// Directed bench for mem_req_arbiter_2x1: routing, round-robin,
// full stall, response backpressure and async reset.
module tb_mem_req_arbiter_2x1;
  import mem_req_arbiter_2x1_pkg::*;

  logic          clk = 1'b0;
  logic          reset;
  mem_req_16B_t  req0_msg, req1_msg, memreq_msg;
  logic          req0_val, req0_rdy, req1_val, req1_rdy;
  mem_resp_16B_t resp0_msg, resp1_msg, memresp_msg;
  logic          resp0_val, resp0_rdy, resp1_val, resp1_rdy;
  logic          memreq_val, memreq_rdy;
  logic          memresp_val, memresp_rdy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_req_arbiter_2x1 #(.p_num_outstanding(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .req0_msg    (req0_msg),
    .req0_val    (req0_val),
    .req0_rdy    (req0_rdy),
    .req1_msg    (req1_msg),
    .req1_val    (req1_val),
    .req1_rdy    (req1_rdy),
    .resp0_msg   (resp0_msg),
    .resp0_val   (resp0_val),
    .resp0_rdy   (resp0_rdy),
    .resp1_msg   (resp1_msg),
    .resp1_val   (resp1_val),
    .resp1_rdy   (resp1_rdy),
    .memreq_msg  (memreq_msg),
    .memreq_val  (memreq_val),
    .memreq_rdy  (memreq_rdy),
    .memresp_msg (memresp_msg),
    .memresp_val (memresp_val),
    .memresp_rdy (memresp_rdy)
  );

  task automatic chk(input string tag, input logic [255:0] obs,
                     input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rdy(input string tag, input logic r0, input logic r1,
                         input logic mv);
    chk({tag, "_req0_rdy"}, 256'(req0_rdy), 256'(r0));
    chk({tag, "_req1_rdy"}, 256'(req1_rdy), 256'(r1));
    chk({tag, "_memreq_val"}, 256'(memreq_val), 256'(mv));
  endtask

  task automatic chk_resp(input string tag, input logic v0, input logic v1,
                          input logic mr);
    chk({tag, "_resp0_val"}, 256'(resp0_val), 256'(v0));
    chk({tag, "_resp1_val"}, 256'(resp1_val), 256'(v1));
    chk({tag, "_memresp_rdy"}, 256'(memresp_rdy), 256'(mr));
  endtask

  function automatic mem_req_16B_t mk_req(input logic [7:0] op,
                                          input logic [31:0] ad);
    mem_req_16B_t m;
    m.type_  = MEM_TYPE_READ;
    m.opaque = op;
    m.addr   = ad;
    m.len    = 4'd0;
    m.data   = '0;
    return m;
  endfunction

  function automatic mem_resp_16B_t mk_resp(input logic [7:0] op,
                                            input logic [127:0] d);
    mem_resp_16B_t m;
    m.type_  = MEM_TYPE_READ;
    m.opaque = op;
    m.test   = 2'd0;
    m.len    = 4'd0;
    m.data   = d;
    return m;
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    mem_req_16B_t  a0, a1;
    mem_resp_16B_t r;
    logic [7:0]    exp_op;

    reset       = 1'b1;
    req0_msg    = '0;
    req1_msg    = '0;
    req0_val    = 1'b0;
    req1_val    = 1'b0;
    resp0_rdy   = 1'b0;
    resp1_rdy   = 1'b0;
    memreq_rdy  = 1'b0;
    memresp_msg = '0;
    memresp_val = 1'b0;

    // Reset state
    step();
    #1;
    chk_rdy("rst", 1'b0, 1'b0, 1'b0);
    chk_resp("rst", 1'b0, 1'b0, 1'b0);

    // Single port 0 read
    step();
    reset      = 1'b0;
    a0         = mk_req(8'h05, 32'h0000_1000);
    req0_msg   = a0;
    req0_val   = 1'b1;
    memreq_rdy = 1'b1;
    #1;
    chk_rdy("single", 1'b1, 1'b0, 1'b1);
    chk("single_msg", 256'(memreq_msg), 256'(a0));
    chk("single_rrdy_empty", 256'(memresp_rdy), 256'(1'b0));

    step();
    req0_val    = 1'b0;
    r           = mk_resp(8'h05, 128'hAABB_AABB_AABB_AABB_AABB_AABB_AABB_AABB);
    memresp_msg = r;
    memresp_val = 1'b1;
    resp0_rdy   = 1'b1;
    resp1_rdy   = 1'b1;
    #1;
    chk_resp("single_rsp", 1'b1, 1'b0, 1'b1);
    chk("single_rsp_msg", 256'(resp0_msg), 256'(r));
    chk("single_idle_mval", 256'(memreq_val), 256'(1'b0));

    step();
    memresp_val = 1'b0;
    #1;
    chk("single_drained", 256'(memresp_rdy), 256'(1'b0));

    // Fresh reset so contention starts with port 0 priority
    reset = 1'b1;
    step();
    reset    = 1'b0;
    a0       = mk_req(8'h10, 32'h0000_2000);
    a1       = mk_req(8'h21, 32'h0000_3000);
    req0_msg = a0;
    req1_msg = a1;
    req0_val = 1'b1;
    req1_val = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      exp_op = i[0] ? 8'h21 : 8'h10;
      chk_rdy($sformatf("cont%0d", i), !i[0], i[0], 1'b1);
      chk($sformatf("cont%0d_op", i), 256'(memreq_msg.opaque), 256'(exp_op));
      step();
    end

    // FIFO now holds IDs 0,1,0,1: full, pop without bypass
    memresp_val = 1'b1;
    memresp_msg = mk_resp(8'hA0, 128'h1);
    #1;
    chk_rdy("full", 1'b0, 1'b0, 1'b0);
    chk_resp("full_pop", 1'b1, 1'b0, 1'b1);

    // Push (port 0) and pop (ID 1) on the same edge
    step();
    memresp_msg = mk_resp(8'hA1, 128'h2);
    #1;
    chk_rdy("after_full", 1'b1, 1'b0, 1'b1);
    chk_resp("pushpop", 1'b0, 1'b1, 1'b1);
    chk("pushpop_msg", 256'(resp1_msg.opaque), 256'(8'hA1));

    // Contents now 1,0,0 -> wait, order is 0,1,0 after push/pop
    step();
    req0_val = 1'b0;
    req1_val = 1'b0;
    memresp_msg = mk_resp(8'hA2, 128'h3);
    #1;
    chk_resp("route_a2", 1'b1, 1'b0, 1'b1);

    // Head is ID 1 with port 1 backpressured
    step();
    resp1_rdy = 1'b0;
    memresp_msg = mk_resp(8'hA3, 128'h4);
    #1;
    chk_resp("bp0", 1'b0, 1'b1, 1'b0);
    step();
    #1;
    chk_resp("bp1", 1'b0, 1'b1, 1'b0);
    step();
    resp1_rdy = 1'b1;
    #1;
    chk_resp("bp_release", 1'b0, 1'b1, 1'b1);

    step();
    memresp_msg = mk_resp(8'hA4, 128'h5);
    #1;
    chk_resp("last", 1'b1, 1'b0, 1'b1);
    chk("last_msg", 256'(resp0_msg.opaque), 256'(8'hA4));

    step();
    memresp_val = 1'b0;
    #1;
    chk("drained", 256'(memresp_rdy), 256'(1'b0));

    // Three outstanding from port 1, then async reset mid-cycle
    req1_val = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk_rdy($sformatf("p1_fill%0d", i), 1'b0, 1'b1, 1'b1);
      step();
    end
    req1_val    = 1'b0;
    memresp_val = 1'b1;
    memresp_msg = mk_resp(8'hB0, 128'h6);
    #1;
    chk_resp("pre_rst", 1'b0, 1'b1, 1'b1);
    #1;
    reset = 1'b1;
    #1;
    chk_resp("async_rst", 1'b0, 1'b0, 1'b0);

    step();
    memresp_val = 1'b0;
    reset       = 1'b0;
    req0_val    = 1'b1;
    req1_val    = 1'b1;
    #1;
    chk_rdy("post_rst_prio", 1'b1, 1'b0, 1'b1);
    chk("post_rst_empty", 256'(memresp_rdy), 256'(1'b0));

    // Refill from empty: four fires then full again
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("refill%0d", i), 256'(memreq_val), 256'(1'b1));
      step();
    end
    #1;
    chk_rdy("refull", 1'b0, 1'b0, 1'b0);

    step();
    req0_val = 1'b0;
    req1_val = 1'b0;
    reset    = 1'b1;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
